// File: rtl/e1_pkg.sv
// Shared types and default constants for the E1 frame demultiplexer.
// The optional FAS/NFAS error counter is enabled with E1_DEMUX_ERR_CNT_EN.
package e1_pkg;

    typedef enum logic [1:0] {
        HUNT         = 2'd0,
        CONFIRM_NFAS = 2'd1,
        CONFIRM_FAS  = 2'd2,
        SYNC         = 2'd3
    } e1_state_e;

    localparam int         E1_SLOTS       = 32;
    localparam logic [7:0] E1_FAS_PATTERN = 8'h1B;
    localparam logic [7:0] E1_FAS_MASK    = 8'h7F;
    localparam int         E1_NFAS_BIT    = 6;
    localparam int         E1_LOSS_CNT    = 3;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/e1_align_fsm.sv
// Frame-alignment hunt/confirm/sync state machine, fed with the slot-0 window.
// With E1_DEMUX_ERR_CNT_EN it also keeps the saturating check-failure count.
module e1_align_fsm
    import e1_pkg::*;
#(
    parameter int                SLOT_W      = 8,
    parameter logic [SLOT_W-1:0] FAS_PATTERN = SLOT_W'(E1_FAS_PATTERN),
    parameter logic [SLOT_W-1:0] FAS_MASK    = SLOT_W'(E1_FAS_MASK),
    parameter int                NFAS_BIT    = E1_NFAS_BIT,
    parameter int                LOSS_CNT    = E1_LOSS_CNT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_bit_en,
    input  logic [SLOT_W-1:0] i_window,
    input  logic              i_slot0_done,
    input  logic              i_parity,
    output e1_state_e         o_state,
    output logic              o_sync,
    output logic              o_hunt_match,
    output logic              o_loss
`ifdef E1_DEMUX_ERR_CNT_EN
    , output logic [15:0]     o_err_cnt
`endif
);

    localparam int LC_W = $clog2(LOSS_CNT + 1);

    e1_state_e         r_state;
    e1_state_e         w_state_nxt;
    logic [LC_W-1:0]   r_loss_cnt;
    logic [LC_W-1:0]   w_loss_cnt_nxt;
    logic              r_sync;
    logic              w_fas_ok;
    logic              w_hunt_match;
    logic              w_loss;

    assign w_fas_ok = ((i_window & FAS_MASK) == (FAS_PATTERN & FAS_MASK));

    // State, loss counter and registered sync flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= HUNT;
            r_loss_cnt <= '0;
            r_sync     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_loss_cnt <= w_loss_cnt_nxt;
            r_sync     <= (w_state_nxt == SYNC);
        end
    end

    // Next-state decisions; every slot-0 check happens on its completing bit.
    always_comb begin
        w_state_nxt    = r_state;
        w_loss_cnt_nxt = r_loss_cnt;
        w_hunt_match   = 1'b0;
        w_loss         = 1'b0;
        case (r_state)
            HUNT: begin
                if (i_bit_en && w_fas_ok) begin
                    w_hunt_match = 1'b1;
                    w_state_nxt  = CONFIRM_NFAS;
                end else begin
                    w_state_nxt  = HUNT;
                end
            end
            CONFIRM_NFAS: begin
                if (i_slot0_done) begin
                    w_state_nxt = i_window[NFAS_BIT] ? CONFIRM_FAS : HUNT;
                end else begin
                    w_state_nxt = CONFIRM_NFAS;
                end
            end
            CONFIRM_FAS: begin
                if (i_slot0_done) begin
                    w_state_nxt    = w_fas_ok ? SYNC : HUNT;
                    w_loss_cnt_nxt = '0;
                end else begin
                    w_state_nxt    = CONFIRM_FAS;
                end
            end
            SYNC: begin
                if (i_slot0_done && !i_parity) begin
                    if (w_fas_ok) begin
                        w_loss_cnt_nxt = '0;
                    end else if (r_loss_cnt == LC_W'(LOSS_CNT - 1)) begin
                        w_loss         = 1'b1;
                        w_state_nxt    = HUNT;
                        w_loss_cnt_nxt = '0;
                    end else begin
                        w_loss_cnt_nxt = r_loss_cnt + LC_W'(1);
                    end
                end else begin
                    w_loss_cnt_nxt = r_loss_cnt;
                end
            end
            default: begin
                w_state_nxt    = HUNT;
                w_loss_cnt_nxt = '0;
            end
        endcase
    end

`ifdef E1_DEMUX_ERR_CNT_EN
    logic        w_chk_fail;
    logic [15:0] r_err_cnt;

    // Any non-HUNT exit to HUNT is a failed check; SYNC also counts tolerated FAS errors.
    assign w_chk_fail = (r_state != HUNT) && i_slot0_done &&
                        ((w_state_nxt == HUNT) || ((r_state == SYNC) && !i_parity && !w_fas_ok));

    // Saturating check-failure counter, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_cnt <= 16'd0;
        end else if (w_chk_fail) begin
            r_err_cnt <= sat_inc16(r_err_cnt);
        end
    end

    assign o_err_cnt = r_err_cnt;
`endif

    assign o_state      = r_state;
    assign o_sync       = r_sync;
    assign o_hunt_match = w_hunt_match;
    assign o_loss       = w_loss;

endmodule

// File: rtl/e1_frame_demux.sv
// E1-class frame demultiplexer: bit deserialiser, per-slot strobe and double-buffered frame bus.
// Define E1_DEMUX_ERR_CNT_EN to add the err_cnt port.
module e1_frame_demux
    import e1_pkg::*;
#(
    parameter int                SLOT_W      = 8,
    parameter int                NUM_SLOTS   = E1_SLOTS,
    parameter logic [SLOT_W-1:0] FAS_PATTERN = SLOT_W'(E1_FAS_PATTERN),
    parameter logic [SLOT_W-1:0] FAS_MASK    = SLOT_W'(E1_FAS_MASK),
    parameter int                NFAS_BIT    = E1_NFAS_BIT,
    parameter int                LOSS_CNT    = E1_LOSS_CNT,
    localparam int               IDX_W       = $clog2(NUM_SLOTS)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        bit_in,
    input  logic                        bit_en,
    output logic                        sync,
    output logic                        frame_start,
    output logic [SLOT_W-1:0]           slot_data,
    output logic [IDX_W-1:0]            slot_idx,
    output logic                        slot_valid,
    output logic [NUM_SLOTS*SLOT_W-1:0] frame_bus,
    output logic                        frame_valid
`ifdef E1_DEMUX_ERR_CNT_EN
    , output logic [15:0]               err_cnt
`endif
);

    localparam int BIT_W = $clog2(SLOT_W);
    localparam int BUS_W = NUM_SLOTS * SLOT_W;

    logic [SLOT_W-1:0] r_shift;
    logic [SLOT_W-1:0] w_shift_nxt;
    logic [BIT_W-1:0]  r_bit_cnt;
    logic [IDX_W-1:0]  r_slot_cnt;
    logic              r_parity;
    logic [BUS_W-1:0]  r_shadow;
    logic [BUS_W-1:0]  w_shadow_nxt;
    logic [BUS_W-1:0]  r_frame_bus;
    logic [SLOT_W-1:0] r_slot_data;
    logic [IDX_W-1:0]  r_slot_idx;
    logic              r_slot_valid;
    logic              r_frame_valid;
    logic              r_frame_start;
    logic              w_slot_done;
    logic              w_slot0_done;
    logic              w_last_slot;
    e1_state_e         w_state;
    logic              w_sync;
    logic              w_hunt_match;
    logic              w_loss;

    assign w_shift_nxt  = {r_shift[SLOT_W-2:0], bit_in};
    assign w_slot_done  = bit_en && (r_bit_cnt == BIT_W'(SLOT_W - 1));
    assign w_last_slot  = (r_slot_cnt == IDX_W'(NUM_SLOTS - 1));
    assign w_slot0_done = w_slot_done && (r_slot_cnt == '0);

    e1_align_fsm #(
        .SLOT_W      (SLOT_W),
        .FAS_PATTERN (FAS_PATTERN),
        .FAS_MASK    (FAS_MASK),
        .NFAS_BIT    (NFAS_BIT),
        .LOSS_CNT    (LOSS_CNT)
    ) u_fsm (
        .clk          (clk),
        .rst          (rst),
        .i_bit_en     (bit_en),
        .i_window     (w_shift_nxt),
        .i_slot0_done (w_slot0_done),
        .i_parity     (r_parity),
        .o_state      (w_state),
        .o_sync       (w_sync),
        .o_hunt_match (w_hunt_match),
        .o_loss       (w_loss)
`ifdef E1_DEMUX_ERR_CNT_EN
        , .o_err_cnt  (err_cnt)
`endif
    );

    // Shadow image with the slot just completed merged in.
    always_comb begin
        w_shadow_nxt = r_shadow;
        w_shadow_nxt[int'(r_slot_cnt) * SLOT_W +: SLOT_W] = w_shift_nxt;
    end

    // Deserialiser, counters, shadow buffer and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift       <= '0;
            r_bit_cnt     <= '0;
            r_slot_cnt    <= '0;
            r_parity      <= 1'b0;
            r_shadow      <= '0;
            r_frame_bus   <= '0;
            r_slot_data   <= '0;
            r_slot_idx    <= '0;
            r_slot_valid  <= 1'b0;
            r_frame_valid <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_slot_valid  <= 1'b0;
            r_frame_valid <= 1'b0;
            r_frame_start <= 1'b0;
            if (bit_en) begin
                r_shift       <= w_shift_nxt;
                r_frame_start <= (w_state == SYNC) && (r_bit_cnt == '0) && (r_slot_cnt == '0);
                // A hunt match means the window just closed on slot 0 of a FAS frame.
                if (w_hunt_match) begin
                    r_bit_cnt  <= '0;
                    r_slot_cnt <= IDX_W'(1);
                    r_parity   <= 1'b0;
                end else if (w_slot_done) begin
                    r_bit_cnt <= '0;
                    if (w_last_slot) begin
                        r_slot_cnt <= '0;
                        r_parity   <= ~r_parity;
                    end else begin
                        r_slot_cnt <= r_slot_cnt + IDX_W'(1);
                    end
                end else begin
                    r_bit_cnt <= r_bit_cnt + BIT_W'(1);
                end

                if (w_loss) begin
                    r_shadow    <= '0;
                    r_frame_bus <= '0;
                    r_slot_data <= '0;
                end else if (w_slot_done && (w_state != HUNT)) begin
                    r_shadow <= w_shadow_nxt;
                    if (w_state == SYNC) begin
                        r_slot_valid <= 1'b1;
                        r_slot_data  <= w_shift_nxt;
                        r_slot_idx   <= r_slot_cnt;
                        if (w_last_slot) begin
                            r_frame_bus   <= w_shadow_nxt;
                            r_frame_valid <= 1'b1;
                        end
                    end
                end
            end
        end
    end

    assign sync        = w_sync;
    assign frame_start = r_frame_start;
    assign slot_data   = r_slot_data;
    assign slot_idx    = r_slot_idx;
    assign slot_valid  = r_slot_valid;
    assign frame_bus   = r_frame_bus;
    assign frame_valid = r_frame_valid;

endmodule

// File: tb/tb_e1_frame_demux.sv
// Directed bench for e1_frame_demux: acquisition, false lock, loss, gapped enable and reset.
// The err_cnt scenario runs only when E1_DEMUX_ERR_CNT_EN is defined.
module tb_e1_frame_demux;

    localparam logic [7:0] FAS  = 8'h1B;
    localparam logic [7:0] NFAS = 8'h40;
    localparam logic [7:0] BAD  = 8'h1A;

    logic         clk = 1'b0;
    logic         rst;
    logic         bit_in;
    logic         bit_en;
    logic         sync;
    logic         frame_start;
    logic [7:0]   slot_data;
    logic [4:0]   slot_idx;
    logic         slot_valid;
    logic [255:0] frame_bus;
    logic         frame_valid;
`ifdef E1_DEMUX_ERR_CNT_EN
    logic [15:0]  err_cnt;
`endif

    int checks = 0;
    int errors = 0;
    int gap    = 0;

    int           sv_cnt  = 0;
    int           fv_cnt  = 0;
    int           fs_cnt  = 0;
    int           fv_bad  = 0;
    int           sv_long = 0;
    logic         prev_sv = 1'b0;
    logic [7:0]   mon_data [32];
    logic [255:0] mon_bus = '0;

    e1_frame_demux u_dut (
        .clk         (clk),
        .rst         (rst),
        .bit_in      (bit_in),
        .bit_en      (bit_en),
        .sync        (sync),
        .frame_start (frame_start),
        .slot_data   (slot_data),
        .slot_idx    (slot_idx),
        .slot_valid  (slot_valid),
        .frame_bus   (frame_bus),
        .frame_valid (frame_valid)
`ifdef E1_DEMUX_ERR_CNT_EN
        , .err_cnt   (err_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Strobe recorder, sampled just after each rising edge.
    always begin
        @(posedge clk);
        #1;
        if (slot_valid) begin
            sv_cnt++;
            mon_data[slot_idx] = slot_data;
        end
        if (slot_valid && prev_sv) sv_long++;
        prev_sv = slot_valid;
        if (frame_valid) begin
            fv_cnt++;
            mon_bus = frame_bus;
            if (!(slot_valid && slot_idx == 5'd31)) fv_bad++;
        end
        if (frame_start) fs_cnt++;
    end

    task automatic do_reset();
        rst    = 1'b1;
        bit_en = 1'b0;
        bit_in = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic send_bit(input logic b);
        bit_in = b;
        bit_en = 1'b1;
        @(negedge clk);
        bit_en = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic send_payload();
        for (int k = 1; k < 32; k++) send_byte(8'(k));
    endtask

    task automatic send_frame(input logic [7:0] s0);
        send_byte(s0);
        send_payload();
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (sync !== 1'b0) begin errors++; $display("FAIL rst_sync got %b want 0", sync); end
        checks++; if (slot_valid !== 1'b0) begin errors++; $display("FAIL rst_slot_valid got %b want 0", slot_valid); end
        checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL rst_frame_valid got %b want 0", frame_valid); end
        checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL rst_frame_start got %b want 0", frame_start); end
        checks++; if (slot_data !== 8'h00) begin errors++; $display("FAIL rst_slot_data got %h want 00", slot_data); end
        checks++; if (slot_idx !== 5'd0) begin errors++; $display("FAIL rst_slot_idx got %0d want 0", slot_idx); end
        checks++; if (frame_bus !== 256'd0) begin errors++; $display("FAIL rst_frame_bus got %h want 0", frame_bus); end
    endtask

    task automatic test_aligned();
        int sv0, fv0, fs0;
        do_reset();
        sv0 = sv_cnt;
        send_frame(FAS);
        send_frame(NFAS);
        checks++; if (sync !== 1'b0) begin errors++; $display("FAIL al_sync_early got %b want 0", sync); end
        send_byte(FAS);
        checks++; if (sync !== 1'b1) begin errors++; $display("FAIL al_sync_rise got %b want 1", sync); end
        checks++; if (sv_cnt !== sv0) begin errors++; $display("FAIL al_early_strobes got %0d want %0d", sv_cnt, sv0); end
        fv0 = fv_cnt;
        send_payload();
        checks++; if (fv_cnt - fv0 !== 1) begin errors++; $display("FAIL al_fv_first got %0d want 1", fv_cnt - fv0); end
        checks++; if (mon_bus[5*8 +: 8] !== 8'h05) begin errors++; $display("FAIL al_bus_slot5 got %h want 05", mon_bus[5*8 +: 8]); end
        sv0 = sv_cnt; fv0 = fv_cnt; fs0 = fs_cnt;
        send_frame(NFAS);
        checks++; if (sv_cnt - sv0 !== 32) begin errors++; $display("FAIL al_sv_count got %0d want 32", sv_cnt - sv0); end
        checks++; if (fv_cnt - fv0 !== 1) begin errors++; $display("FAIL al_fv_count got %0d want 1", fv_cnt - fv0); end
        checks++; if (fs_cnt - fs0 !== 1) begin errors++; $display("FAIL al_fs_count got %0d want 1", fs_cnt - fs0); end
        checks++; if (mon_data[0] !== NFAS) begin errors++; $display("FAIL al_slot0 got %h want 40", mon_data[0]); end
        for (int k = 1; k < 32; k++) begin
            checks++; if (mon_data[k] !== 8'(k)) begin errors++; $display("FAIL al_slot_data[%0d] got %h want %h", k, mon_data[k], 8'(k)); end
            checks++; if (mon_bus[k*8 +: 8] !== 8'(k)) begin errors++; $display("FAIL al_bus[%0d] got %h want %h", k, mon_bus[k*8 +: 8], 8'(k)); end
        end
        repeat (3) @(negedge clk);
        checks++; if (slot_valid !== 1'b0) begin errors++; $display("FAIL al_sv_drop got %b want 0", slot_valid); end
        checks++; if (slot_data !== 8'h1F) begin errors++; $display("FAIL al_data_hold got %h want 1f", slot_data); end
        checks++; if (slot_idx !== 5'd31) begin errors++; $display("FAIL al_idx_hold got %0d want 31", slot_idx); end
        checks++; if (fv_bad !== 0) begin errors++; $display("FAIL al_fv_align got %0d want 0", fv_bad); end
        checks++; if (sv_long !== 0) begin errors++; $display("FAIL al_sv_width got %0d want 0", sv_long); end
    endtask

    task automatic test_loss();
        int sv0, fv0;
        send_frame(BAD);  send_frame(NFAS);
        send_frame(BAD);  send_frame(NFAS);
        checks++; if (sync !== 1'b1) begin errors++; $display("FAIL loss_two_err got %b want 1", sync); end
        send_frame(FAS);  send_frame(NFAS);
        send_frame(BAD);  send_frame(NFAS);
        send_frame(BAD);  send_frame(NFAS);
        checks++; if (sync !== 1'b1) begin errors++; $display("FAIL loss_cnt_clear got %b want 1", sync); end
        sv0 = sv_cnt; fv0 = fv_cnt;
        send_byte(BAD);
        checks++; if (sync !== 1'b0) begin errors++; $display("FAIL loss_sync_fall got %b want 0", sync); end
        checks++; if (frame_bus !== 256'd0) begin errors++; $display("FAIL loss_frame_bus got %h want 0", frame_bus); end
        checks++; if (slot_data !== 8'h00) begin errors++; $display("FAIL loss_slot_data got %h want 00", slot_data); end
        checks++; if (sv_cnt !== sv0) begin errors++; $display("FAIL loss_slot0_strobe got %0d want %0d", sv_cnt, sv0); end
        send_payload();
        send_frame(FAS);
        checks++; if (sv_cnt !== sv0) begin errors++; $display("FAIL loss_strobes_stop got %0d want %0d", sv_cnt, sv0); end
        checks++; if (fv_cnt !== fv0) begin errors++; $display("FAIL loss_fv_stop got %0d want %0d", fv_cnt, fv0); end
    endtask

    task automatic test_false_fas();
        int sv0;
        do_reset();
        sv0 = sv_cnt;
        send_byte(FAS);
        repeat (32) send_byte(8'h00);
        checks++; if (sync !== 1'b0) begin errors++; $display("FAIL ff_sync_after_check got %b want 0", sync); end
        send_frame(FAS);
        send_frame(NFAS);
        checks++; if (sync !== 1'b0) begin errors++; $display("FAIL ff_sync_early got %b want 0", sync); end
        send_byte(FAS);
        checks++; if (sync !== 1'b1) begin errors++; $display("FAIL ff_relock got %b want 1", sync); end
        checks++; if (sv_cnt !== sv0) begin errors++; $display("FAIL ff_no_strobes got %0d want %0d", sv_cnt, sv0); end
    endtask

    task automatic test_offset();
        int sv0, fv0;
        logic [12:0] junk;
        junk = 13'b1010101010101;
        do_reset();
        sv0 = sv_cnt;
        for (int i = 12; i >= 0; i--) send_bit(junk[i]);
        send_frame(FAS);
        send_frame(NFAS);
        send_byte(FAS);
        checks++; if (sync !== 1'b1) begin errors++; $display("FAIL off_sync got %b want 1", sync); end
        checks++; if (sv_cnt !== sv0) begin errors++; $display("FAIL off_no_strobes got %0d want %0d", sv_cnt, sv0); end
        fv0 = fv_cnt;
        send_payload();
        checks++; if (fv_cnt - fv0 !== 1) begin errors++; $display("FAIL off_fv got %0d want 1", fv_cnt - fv0); end
        for (int k = 1; k < 32; k++) begin
            checks++; if (mon_bus[k*8 +: 8] !== 8'(k)) begin errors++; $display("FAIL off_bus[%0d] got %h want %h", k, mon_bus[k*8 +: 8], 8'(k)); end
        end
    endtask

    task automatic test_gapped();
        int fv0;
        gap = 2;
        do_reset();
        send_frame(FAS);
        send_frame(NFAS);
        send_byte(FAS);
        checks++; if (sync !== 1'b1) begin errors++; $display("FAIL gap_sync got %b want 1", sync); end
        fv0 = fv_cnt;
        send_payload();
        checks++; if (fv_cnt - fv0 !== 1) begin errors++; $display("FAIL gap_fv got %0d want 1", fv_cnt - fv0); end
        checks++; if (mon_bus[5*8 +: 8] !== 8'h05) begin errors++; $display("FAIL gap_bus_slot5 got %h want 05", mon_bus[5*8 +: 8]); end
        send_byte(NFAS);
        send_byte(8'h01);
        send_bit(1'b0); send_bit(1'b0); send_bit(1'b0);
        fv0 = fv_cnt;
        do_reset();
        checks++; if (sync !== 1'b0) begin errors++; $display("FAIL gap_rst_sync got %b want 0", sync); end
        checks++; if (frame_bus !== 256'd0) begin errors++; $display("FAIL gap_rst_bus got %h want 0", frame_bus); end
        checks++; if (slot_data !== 8'h00) begin errors++; $display("FAIL gap_rst_data got %h want 00", slot_data); end
        checks++; if (slot_idx !== 5'd0) begin errors++; $display("FAIL gap_rst_idx got %0d want 0", slot_idx); end
        checks++; if (fv_cnt !== fv0) begin errors++; $display("FAIL gap_rst_partial got %0d want %0d", fv_cnt, fv0); end
        send_frame(FAS);
        send_frame(NFAS);
        checks++; if (sync !== 1'b0) begin errors++; $display("FAIL gap_reacq_early got %b want 0", sync); end
        send_byte(FAS);
        checks++; if (sync !== 1'b1) begin errors++; $display("FAIL gap_reacq got %b want 1", sync); end
        send_payload();
        for (int k = 1; k < 32; k++) begin
            checks++; if (mon_bus[k*8 +: 8] !== 8'(k)) begin errors++; $display("FAIL gap_bus[%0d] got %h want %h", k, mon_bus[k*8 +: 8], 8'(k)); end
        end
        gap = 0;
    endtask

`ifdef E1_DEMUX_ERR_CNT_EN
    task automatic test_err_cnt();
        gap = 0;
        do_reset();
        checks++; if (err_cnt !== 16'd0) begin errors++; $display("FAIL ec_reset got %h want 0000", err_cnt); end
        send_frame(FAS);
        send_frame(NFAS);
        send_byte(FAS);
        send_payload();
        for (int i = 0; i < 5; i++) begin
            send_frame(NFAS);
            send_frame(BAD);
            send_frame(NFAS);
            send_frame(FAS);
        end
        checks++; if (err_cnt !== 16'd5) begin errors++; $display("FAIL ec_five got %0d want 5", err_cnt); end
        checks++; if (sync !== 1'b1) begin errors++; $display("FAIL ec_sync_kept got %b want 1", sync); end
        force u_dut.u_fsm.r_err_cnt = 16'hFFFF;
        @(negedge clk);
        release u_dut.u_fsm.r_err_cnt;
        send_frame(NFAS);
        send_frame(BAD);
        checks++; if (err_cnt !== 16'hFFFF) begin errors++; $display("FAIL ec_saturate got %h want ffff", err_cnt); end
    endtask
`endif

    initial begin
        rst    = 1'b1;
        bit_en = 1'b0;
        bit_in = 1'b0;
        @(negedge clk);
        test_reset();
        test_aligned();
        test_loss();
        test_false_fas();
        test_offset();
        test_gapped();
`ifdef E1_DEMUX_ERR_CNT_EN
        test_err_cnt();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
